decoder_3_8_buf: RTL
====================

# decoder_3_8_buf

Buffered 3:8 decoder that receives encoded indices from the 8:3 priority encoder, queues them in a small FIFO, and presents each as a one-hot 8-bit word over a valid/ready handshake. It sits downstream of the encoder and turns the encoder's `out`/`valid` pair back into one-hot select lines for a consumer that may stall. The buffer decouples the encoder, which produces a result every cycle, from a consumer that is not always ready.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries; must be a power of 2, minimum 2.
- `PTR_W`, default 2: pointer width, equal to log2(DEPTH).

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in`, input, 3: encoded index, from the encoder's `out`.
- `in_valid`, input, 1: index present, from the encoder's `valid`.
- `in_ready`, output, 1: FIFO can accept an index this cycle.
- `out`, output, 8: one-hot decode of the FIFO head; 8'h00 when empty.
- `out_valid`, output, 1: `out` holds a queued entry.
- `out_ready`, input, 1: consumer accepts `out` this cycle.
- `count`, output, PTR_W+1: current occupancy, 0..DEPTH.
- `overflow`, output, 1: sticky flag, set when `in_valid` is high while `in_ready` is low.

## Operation

- Storage is DEPTH entries of 3 bits, with `wr_ptr` and `rd_ptr` (each PTR_W bits) and an occupancy counter `count`.
- Push occurs when `in_valid && in_ready`:
  - `in` is written at `wr_ptr`.
  - `wr_ptr` increments and wraps from DEPTH-1 to 0.
- Pop occurs when `out_valid && out_ready`:
  - `rd_ptr` increments and wraps from DEPTH-1 to 0.
- Counter update:
  - `count` +1 on push only.
  - `count` -1 on pop only.
  - `count` unchanged when both or neither occur.
- Status outputs:
  - `in_ready = (count != DEPTH)`. It depends only on registered state, with no combinational path from `out_ready`.
  - `out_valid = (count != 0)`.
  - `out = out_valid ? (8'b1 << mem[rd_ptr]) : 8'h00`. Exactly one bit is set whenever `out_valid` is 1.
- Full condition (`count == DEPTH`):
  - `in_ready` is 0, so a simultaneous pop does not enable a same-cycle push.
  - The entry is refused, and `overflow` sets if `in_valid` is 1.
- Empty condition (`count == 0`):
  - A pop is impossible.
  - A push is visible on `out` in the next cycle. There is no same-cycle bypass.
- Push and pop in the same cycle when 0 < count < DEPTH: both pointers advance and `count` holds.
- `in_valid == 0` is the encoder's "no request line active" case. Nothing is queued, and `in` is ignored.
- `overflow` stays at 1 until `rst`. Refused entries are discarded without affecting FIFO contents.
- State elements are `wr_ptr`, `rd_ptr`, `count`, `overflow`, and `mem`. There is no other FSM; the full and empty status is derived from `count`.

## Timing

- Reset (rst=1 at a rising edge) takes effect at that edge. Afterwards:
  - `count` = 0, `wr_ptr` = 0, `rd_ptr` = 0, `overflow` = 0.
  - `out_valid` = 0 and `out` = 8'h00.
  - `in_ready` = 1.
  - `mem` contents are don't-care.
- `rst` has priority over a push or pop in the same cycle. A reset mid-stream discards all queued entries.
- Latency from a push at edge N into an empty FIFO: `out_valid` = 1 and `out` valid after edge N.
- The handshake is sampled at the rising edge. The consumer may hold `out_ready` high continuously, giving 1 entry per cycle of sustained throughput.
- `out` and `out_valid` remain stable while `out_valid && !out_ready`.
- Entries leave in FIFO order with no reordering.

## Test plan

- **Reset:** assert `rst` for 2 cycles with `in_valid=1`, `in=3'd5` → `count=0`, `out=8'h00`, `out_valid=0`, `in_ready=1`, `overflow=0`.
- **Single pass-through:** with `out_ready=1`, push `in=3'd6` for one cycle → next cycle `out=8'b0100_0000` and `out_valid=1`; the cycle after, `out_valid=0`.
- **Fill and overflow:** with `out_ready=0`, push 3'd0, 3'd1, 3'd2, 3'd3, then 3'd7 →
  - `count=4` and `in_ready=0`;
  - `overflow=1`;
  - raising `out_ready` drains 8'h01, 8'h02, 8'h04, 8'h08, and 8'h80 never appears.
- **Wrap and simultaneous push/pop:**
  - With `count=2`, push and pop every cycle for 10 cycles (inputs 0..7, 0, 1) → `count` stays 2.
  - Outputs appear in order, 2 cycles behind the inputs, across pointer wrap.
- **Reset mid-operation:** with `count=3`, assert `rst` → `count=0`, `out_valid=0`, `overflow=0`; the next push of 3'd4 yields `out=8'h10`.
- **Exhaustive encoder chain:** drive the 8:3 priority encoder over `in = 0..255` into this block with `out_ready=1` →
  - for each nonzero input, `out` equals the highest set input bit one cycle later;
  - input 0 produces no entry.

Source files
------------

// File: rtl/decoder_3_8_buf.sv
// ============================================================================
// decoder_3_8_buf
// ----------------------------------------------------------------------------
// Buffered 3:8 decoder. Encoded indices arriving from an 8:3 priority encoder
// are queued in a small FIFO. The head entry is presented as a one-hot 8-bit
// word over a valid/ready handshake, so a consumer that stalls does not lose
// results the encoder produces every cycle.
//
// Parameters
//   DEPTH     FIFO entries (power of 2, >= 2)
//   PTR_W     pointer width, log2(DEPTH)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in         encoded index (encoder `out`)
//   in_valid   index present (encoder `valid`)
//   in_ready   FIFO can accept an index this cycle
//   out        one-hot decode of the FIFO head, 8'h00 when empty
//   out_valid  `out` holds a queued entry
//   out_ready  consumer accepts `out` this cycle
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: an index was offered while the FIFO was full
// ============================================================================
module decoder_3_8_buf #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [2:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Status comes only from the registered count, so there is no
    // combinational path from out_ready to in_ready: a full FIFO refuses a
    // push even in a cycle where the consumer pops.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves it unassigned and no latch appears.
    always_comb begin
        out = 8'h00;
        if (out_valid) begin
            out = 8'b1 << mem[rd_ptr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase

            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; entries are only read once
    // count says they were written, so their power-up value never matters.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in;
        end
    end

endmodule
